// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: T-state micro-sequencer that drives the adder/accumulator control word
module sap_control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_instr_valid,
    output logic       o_instr_ready,
    input  logic [2:0] i_opcode,
    input  logic [7:0] i_operand,
    output logic       o_bus_oe,
    output logic [7:0] o_bus_data,
    output logic       o_nla,
    output logic       o_nlb,
    output logic       o_ea,
    output logic       o_eu,
    output logic       o_sub,
    input  logic [7:0] i_acc_in,
    input  logic       i_cf_in,
    input  logic       i_zf_in,
    output logic       o_carry,
    output logic       o_zero,
    output logic [7:0] o_out_data,
    output logic       o_out_valid,
    output logic       o_done,
    output logic       o_halted,
    output logic       o_err
);
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_LDB = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;
    localparam logic [2:0] OP_HLT = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    typedef enum logic [2:0] {IDLE, EX1, EX2, DONE, HALT} state_t;

    state_t     r_state, w_next;
    logic [2:0] r_op;
    logic       w_accept, w_is_alu;
    logic       w_bus_oe, w_nla, w_nlb, w_ea, w_eu, w_sub;
    logic [7:0] w_bus_data;

    // Every output is registered, so the word for EX1 is computed from the opcode being accepted
    // and the word for every other state is the idle word.
    assign w_accept = (r_state == IDLE) && i_instr_valid;
    assign w_is_alu = (r_op == OP_ADD) || (r_op == OP_SUB);

    // Next state and the control word that will be presented in that next state
    always_comb begin
        w_next     = r_state;
        w_bus_oe   = 1'b0;
        w_bus_data = 8'h00;
        w_nla      = 1'b1;
        w_nlb      = 1'b1;
        w_ea       = 1'b0;
        w_eu       = 1'b0;
        w_sub      = 1'b0;
        case (r_state)
            IDLE: if (w_accept) begin
                w_next     = EX1;
                w_bus_oe   = (i_opcode == OP_LDA) || (i_opcode == OP_LDB);
                w_bus_data = w_bus_oe ? i_operand : 8'h00;
                w_nla      = !((i_opcode == OP_LDA) || (i_opcode == OP_ADD) || (i_opcode == OP_SUB));
                w_nlb      = i_opcode != OP_LDB;
                w_ea       = i_opcode == OP_OUT;
                w_eu       = (i_opcode == OP_ADD) || (i_opcode == OP_SUB);
                w_sub      = i_opcode == OP_SUB;
            end
            EX1:     w_next = w_is_alu ? EX2 : (r_op == OP_HLT) ? HALT : DONE;
            EX2:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = HALT;
        endcase
    end

    // State, registered control word, status flags and captured datapath values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_op          <= 3'd0;
            o_instr_ready <= 1'b1;
            o_bus_oe      <= 1'b0;
            o_bus_data    <= 8'h00;
            o_nla         <= 1'b1;
            o_nlb         <= 1'b1;
            o_ea          <= 1'b0;
            o_eu          <= 1'b0;
            o_sub         <= 1'b0;
            o_carry       <= 1'b0;
            o_zero        <= 1'b0;
            o_out_data    <= 8'h00;
            o_out_valid   <= 1'b0;
            o_done        <= 1'b0;
            o_halted      <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            r_state       <= w_next;
            o_instr_ready <= w_next == IDLE;
            o_bus_oe      <= w_bus_oe;
            o_bus_data    <= w_bus_data;
            o_nla         <= w_nla;
            o_nlb         <= w_nlb;
            o_ea          <= w_ea;
            o_eu          <= w_eu;
            o_sub         <= w_sub;
            o_done        <= w_next == DONE;
            o_halted      <= w_next == HALT;
            o_out_valid   <= (r_state == EX1) && (r_op == OP_OUT);
            if (w_accept)
                r_op <= i_opcode;
            if ((r_state == EX1) && (r_op == OP_OUT))
                o_out_data <= i_acc_in;
            if ((r_state == EX1) && (r_op == OP_ILL))
                o_err <= 1'b1;
            if (r_state == EX2) begin
                o_carry <= i_cf_in;
                o_zero  <= i_zf_in;
            end
        end
    end
endmodule
